// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative RV32M multiply/divide, one bit per cycle, valid/ready request and response.
module mul_div_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [3:0]       io_req_fn,
  input  logic [XLEN-1:0]  io_req_in1,
  input  logic [XLEN-1:0]  io_req_in2,
  input  logic [TAG_W-1:0] io_req_tag,
  input  logic             io_kill,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_data,
  output logic [TAG_W-1:0] io_resp_tag
);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [63:0] p, step, prod;
  logic [31:0] d, abs1, abs2, res, q, r;
  logic [32:0] add_s, sub_t, sub_d;
  logic [4:0]  cnt;
  logic [2:0]  fn;
  logic        s1, neg, dz, sg1, sg2, is_div;
  assign is_div = io_req_fn[2];
  assign sg1 = (io_req_fn[2:0] == 3'd1 || io_req_fn[2:0] == 3'd2 ||
                io_req_fn[2:0] == 3'd4 || io_req_fn[2:0] == 3'd6) && io_req_in1[31];
  assign sg2 = (io_req_fn[2:0] == 3'd1 || io_req_fn[2:0] == 3'd4 ||
                io_req_fn[2:0] == 3'd6) && io_req_in2[31];
  assign abs1 = sg1 ? -io_req_in1 : io_req_in1;
  assign abs2 = sg2 ? -io_req_in2 : io_req_in2;
  // p holds {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div
  assign add_s = {1'b0, p[63:32]} + {1'b0, p[0] ? d : 32'd0};
  assign sub_t = p[63:31];
  assign sub_d = sub_t - {1'b0, d};
  assign step  = !fn[2] ? {add_s, p[31:1]} :
                 sub_d[32] ? {sub_t[31:0], p[30:0], 1'b0} : {sub_d[31:0], p[30:0], 1'b1};
  assign prod = neg ? -p : p;
  assign q    = p[31:0];
  assign r    = p[63:32];
  // a zero divisor yields all-ones quotient unsigned, and |in1| re-signed gives in1 back
  assign res  = !fn[2] ? (fn[1:0] == 2'd0 ? prod[31:0] : prod[63:32]) :
                fn[1] ? (s1 ? -r : r) : ((neg && !dz) ? -q : q);
  assign io_req_ready  = state == IDLE;
  assign io_resp_valid = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = io_req_valid ? BUSY : IDLE;
      BUSY:    state_nx = cnt == 5'd31 ? FIX : BUSY;
      FIX:     state_nx = DONE;
      default: state_nx = io_resp_ready ? IDLE : DONE;
    endcase
    if (io_kill && state != IDLE) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      p            <= '0;
      d            <= '0;
      cnt          <= '0;
      fn           <= '0;
      s1           <= 1'b0;
      neg          <= 1'b0;
      dz           <= 1'b0;
      io_resp_data <= '0;
      io_resp_tag  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && io_req_valid) begin
        p           <= {32'd0, is_div ? abs1 : abs2};
        d           <= is_div ? abs2 : abs1;
        cnt         <= '0;
        fn          <= io_req_fn[2:0];
        s1          <= sg1;
        neg         <= sg1 ^ sg2;
        dz          <= io_req_in2 == '0;
        io_resp_tag <= io_req_tag;
      end
      if (state == BUSY) begin
        p   <= step;
        cnt <= cnt + 5'd1;
      end
      if (state == FIX) io_resp_data <= res;
    end
  end
endmodule

// File: tb/tb_mul_div_iter.sv
// tb_mul_div_iter: directed vectors for the iterative mul/div unit with hand-computed results.
module tb_mul_div_iter;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        io_req_valid = 1'b0, io_req_ready, io_kill = 1'b0;
  logic [3:0]  io_req_fn = '0;
  logic [31:0] io_req_in1 = '0, io_req_in2 = '0, io_resp_data;
  logic [4:0]  io_req_tag = '0, io_resp_tag;
  logic        io_resp_valid, io_resp_ready = 1'b0;
  int total = 0, bad = 0;
  mul_div_iter dut (
    .clock(clock), .reset_n(reset_n), .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_fn(io_req_fn), .io_req_in1(io_req_in1), .io_req_in2(io_req_in2), .io_req_tag(io_req_tag),
    .io_kill(io_kill), .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_tag(io_resp_tag)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic start(input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    @(negedge clock);
    io_req_fn = fn; io_req_in1 = x; io_req_in2 = y; io_req_tag = t; io_req_valid = 1'b1;
    @(posedge clock);
    #1 io_req_valid = 1'b0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!io_resp_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
  endtask
  task automatic take();
    @(negedge clock) io_resp_ready = 1'b1;
    @(posedge clock);
    #1 io_resp_ready = 1'b0;
  endtask
  task automatic op(input string name, input logic [3:0] fn, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] exp);
    int lat;
    start(fn, x, y, 5'd1);
    wait_resp(lat);
    chk(name, io_resp_data, exp);
    take();
  endtask
  initial begin
    int lat, hi;
    logic [31:0] d0;
    logic [4:0]  t0;
    #12;
    chk("rst_ready", {31'd0, io_req_ready}, 32'd1);
    chk("rst_valid", {31'd0, io_resp_valid}, 32'd0);
    chk("rst_data", io_resp_data, 32'd0);
    chk("rst_tag", {27'd0, io_resp_tag}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    start(4'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    wait_resp(lat);
    chk("mul_lat", lat, 32'd33);
    chk("mul_data", io_resp_data, 32'hFFFFFFEB);
    chk("mul_tag", {27'd0, io_resp_tag}, 32'd5);
    take();
    chk("idle_valid", {31'd0, io_resp_valid}, 32'd0);
    chk("idle_ready", {31'd0, io_req_ready}, 32'd1);
    op("mulh", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    op("mulhsu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op("mulhu", 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op("mulhu_2", 4'd3, 32'h80000000, 32'd2, 32'd1);
    op("fn3_ign", 4'd8, 32'd7, 32'd3, 32'd21);
    op("div_neg", 4'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    op("rem_neg", 4'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    op("divu_big", 4'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    op("remu_big", 4'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    op("divu", 4'd5, 32'd100, 32'd7, 32'd14);
    op("remu", 4'd7, 32'd100, 32'd7, 32'd2);
    op("div_z", 4'd4, 32'h1234, 32'd0, 32'hFFFFFFFF);
    op("divu_z", 4'd5, 32'h1234, 32'd0, 32'hFFFFFFFF);
    op("rem_z", 4'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
    op("remu_z", 4'd7, 32'h1234, 32'd0, 32'h1234);
    op("div_ovf", 4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    op("rem_ovf", 4'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    start(4'd0, 32'd9, 32'd9, 5'd17);
    wait_resp(lat);
    d0 = io_resp_data; t0 = io_resp_tag;
    chk("hold_data0", d0, 32'd81);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("hold_stable", {io_resp_valid, io_req_ready, io_resp_tag, io_resp_data[24:0]},
          {1'b1, 1'b0, 5'd17, d0[24:0]});
    end
    take();
    chk("hold_release", {30'd0, io_resp_valid, io_req_ready}, 32'd1);
    start(4'd5, 32'd100, 32'd7, 5'd3);
    repeat (11) @(posedge clock);
    @(negedge clock) io_kill = 1'b1;
    @(posedge clock);
    #1 io_kill = 1'b0;
    chk("kill_idle", {30'd0, io_resp_valid, io_req_ready}, 32'd1);
    hi = 0;
    repeat (40) begin
      @(posedge clock);
      #1 if (io_resp_valid) hi++;
    end
    chk("kill_quiet", hi, 32'd0);
    start(4'd0, 32'd6, 32'd7, 5'd9);
    wait_resp(lat);
    chk("after_kill_lat", lat, 32'd33);
    chk("after_kill_data", io_resp_data, 32'd42);
    chk("after_kill_tag", {27'd0, io_resp_tag}, 32'd9);
    @(negedge clock) begin io_kill = 1'b1; io_resp_ready = 1'b1; end
    @(posedge clock);
    #1 begin io_kill = 1'b0; io_resp_ready = 1'b0; end
    chk("kill_done", {30'd0, io_resp_valid, io_req_ready}, 32'd1);
    start(4'd3, 32'd5, 32'd5, 5'd4);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flags", {30'd0, io_resp_valid, io_req_ready}, 32'd1);
    chk("arst_data", io_resp_data, 32'd0);
    chk("arst_tag", {27'd0, io_resp_tag}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    op("post_rst", 4'd0, 32'd11, 32'd11, 32'd121);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
